// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bundles the producer push side, the FIFO status flags and
// the uart_tx handshake of uart_tx_fifo.
//   wr_en/wr_data     push strobe and byte from the producer
//   full/empty/count  registered occupancy status
//   overflow/ovf_clr  sticky dropped-push flag and its synchronous clear
//   tx_busy           busy indication from uart_tx
//   tx_data/tx_pluse  byte and one-cycle start strobe to uart_tx
// master = producer/uart_tx side, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_pluse;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_pluse
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy,
    output full, empty, count, overflow, tx_data, tx_pluse
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain controller feeding uart_tx.
// Producers push at clock rate; the controller pops one byte at a time,
// presents it on tx_data with a one-cycle tx_pluse, then waits for uart_tx
// to raise and drop tx_busy (or gives up after BUSY_TO cycles) before the
// next pop.
//   clk   rising-edge system clock
//   rstn  asynchronous active-low reset
//   bus   uart_tx_fifo_if.slave (push side, status, uart_tx handshake)
module uart_tx_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned BUSY_TO = 8
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned TO_W = $clog2(BUSY_TO) + 1;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_nxt;
  logic            full_q;
  logic            empty_q;
  logic            overflow_q;
  logic [7:0]      tx_data_q;
  logic            tx_pluse_q;
  logic [TO_W-1:0] to_cnt;
  logic            push;
  logic            pop;

  assign push = bus.wr_en && !full_q;
  // Pop only from IDLE, judged on the registered empty flag: no fall-through.
  assign pop  = (state == IDLE) && !empty_q && !bus.tx_busy;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + PTR_ONE;
    end else if (pop && !push) begin
      count_nxt = count_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  // Flags are registered from next-count so they always agree with count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      // A dropped push sets the flag even if a clear arrives the same cycle.
      if (bus.wr_en && full_q) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      tx_data_q  <= '0;
      tx_pluse_q <= 1'b0;
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem[rd_ptr[ADDR_W-1:0]];
            tx_pluse_q <= 1'b1;
            state      <= PULSE;
          end
        end
        PULSE: begin
          tx_pluse_q <= 1'b0;
          to_cnt     <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // uart_tx never acknowledged: treat the byte as sent, no retry.
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_pluse = tx_pluse_q;

endmodule
